// File: rtl/mem_access_unit.sv
// Data-memory initiator: load/store over valid/ready, byte-accurate responses.
// Sub-word stores are done as a read-modify-write with full-word writes.
module mem_access_unit #(
    parameter int MEM_WORDS = 1024,
    parameter bit ERR_OOR   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_ce,
    output logic        mem_we,
    output logic        mem_rr,
    output logic [3:0]  mem_w_mask,
    output logic [3:0]  mem_r_mask,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RMW_RD,
        S_RMW_WR,
        S_ST_W,
        S_RESP
    } state_t;

    localparam logic [31:0] MW = 32'(MEM_WORDS);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] old_q, old_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        err_q, err_d;

    logic        bad;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] ext;
    logic [31:0] merged;
    logic [29:0] idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            old_q   <= '0;
            rdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            old_q   <= old_d;
            rdata_q <= rdata_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
        end
    end

    // Request legality is judged on the live inputs at the accept edge.
    always_comb begin
        bad = 1'b0;
        unique case (req_size)
            2'b00:   bad = 1'b0;
            2'b01:   bad = req_addr[0];
            2'b10:   bad = |req_addr[1:0];
            default: bad = 1'b1;
        endcase
        if (ERR_OOR && ({2'b00, req_addr[31:2]} >= MW)) bad = 1'b1;
    end

    assign idx = 30'({2'b00, addr_q[31:2]} % MW);

    always_comb begin
        rd_byte = mem_rdata[7:0];
        unique case (addr_q[1:0])
            2'b00:   rd_byte = mem_rdata[7:0];
            2'b01:   rd_byte = mem_rdata[15:8];
            2'b10:   rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ext = mem_rdata;
        unique case (size_q)
            2'b00:   ext = {{24{rd_byte[7] & ~uns_q}}, rd_byte};
            2'b01:   ext = {{16{rd_half[15] & ~uns_q}}, rd_half};
            default: ext = mem_rdata;
        endcase
    end

    always_comb begin
        merged = wdata_q;
        if (size_q == 2'b00) begin
            merged = old_q;
            unique case (addr_q[1:0])
                2'b00:   merged[7:0]   = wdata_q[7:0];
                2'b01:   merged[15:8]  = wdata_q[7:0];
                2'b10:   merged[23:16] = wdata_q[7:0];
                default: merged[31:24] = wdata_q[7:0];
            endcase
        end else if (size_q == 2'b01) begin
            merged = addr_q[1] ? {wdata_q[15:0], old_q[15:0]}
                               : {old_q[31:16], wdata_q[15:0]};
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        old_d      = old_q;
        rdata_d    = rdata_q;
        size_d     = size_q;
        uns_d      = uns_q;
        err_d      = err_q;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        mem_ce     = 1'b0;
        mem_we     = 1'b0;
        mem_rr     = 1'b0;
        mem_w_mask = 4'b0000;
        mem_r_mask = 4'b0000;
        mem_addr   = '0;
        mem_wdata  = '0;
        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    err_d   = bad;
                    if (bad) begin
                        rdata_d = '0;
                        state_d = S_RESP;
                    end else if (!req_we) begin
                        state_d = S_LOAD;
                    end else if (req_size == 2'b10) begin
                        state_d = S_ST_W;
                    end else begin
                        state_d = S_RMW_RD;
                    end
                end
            end
            S_LOAD: begin
                mem_ce     = 1'b1;
                mem_rr     = 1'b1;
                mem_r_mask = 4'b1111;
                mem_addr   = {idx, 2'b00};
                rdata_d    = ext;
                state_d    = S_RESP;
            end
            S_RMW_RD: begin
                mem_ce     = 1'b1;
                mem_rr     = 1'b1;
                mem_r_mask = 4'b1111;
                mem_addr   = {idx, 2'b00};
                old_d      = mem_rdata;
                state_d    = S_RMW_WR;
            end
            S_RMW_WR: begin
                mem_ce     = 1'b1;
                mem_we     = 1'b1;
                mem_w_mask = 4'b1111;
                mem_addr   = {idx, 2'b00};
                mem_wdata  = merged;
                rdata_d    = '0;
                state_d    = S_RESP;
            end
            S_ST_W: begin
                mem_ce     = 1'b1;
                mem_we     = 1'b1;
                mem_w_mask = 4'b1111;
                mem_addr   = {idx, 2'b00};
                mem_wdata  = wdata_q;
                rdata_d    = '0;
                state_d    = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_err   = err_q;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed spec cases plus random ops
// checked against a word-array reference model.
module tb_mem_access_unit;

    localparam int MW = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_ce, mem_we, mem_rr;
    logic [3:0]  mem_w_mask, mem_r_mask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    mem_access_unit #(.MEM_WORDS(MW), .ERR_OOR(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata),
        .mem_ce(mem_ce), .mem_we(mem_we), .mem_rr(mem_rr),
        .mem_w_mask(mem_w_mask), .mem_r_mask(mem_r_mask),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [MW];
    assign mem_rdata = mem[mem_addr[11:2]];
    always @(posedge clk) if (mem_ce && mem_we) mem[mem_addr[11:2]] <= mem_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    int r_lat, r_rr, r_we, r_ce, r_rr_at, r_we_at, r_viol;
    logic [31:0] r_rd, r_wd;
    logic r_err;

    logic [31:0] ref_mem [16];

    function automatic logic exp_err(input logic [1:0] sz, input logic [31:0] a);
        int bytes;
        bytes = 1 << sz;
        return (sz == 2'd3) || ((a % bytes) != 0) || ((a / 4) >= MW);
    endfunction

    function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [1:0] sz,
                                             input logic uns, input logic [31:0] a);
        logic [31:0] v;
        v = w >> (8 * (a % 4));
        if (sz == 2'd0) begin
            v = v & 32'hff;
            if (!uns && v >= 32'h80) v = v | 32'hffffff00;
        end else if (sz == 2'd1) begin
            v = v & 32'hffff;
            if (!uns && v >= 32'h8000) v = v | 32'hffff0000;
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_merge(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] m;
        if (sz == 2'd2) return wd;
        m = ((sz == 2'd0) ? 32'hff : 32'hffff) << (8 * (a % 4));
        return (old & ~m) | ((wd << (8 * (a % 4))) & m);
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_size = sz;
        req_unsigned = uns; req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_unsigned = 1'($urandom);
        r_lat = -1; r_rr = 0; r_we = 0; r_ce = 0;
        r_rr_at = -1; r_we_at = -1; r_viol = 0; r_wd = '0; r_rd = '0; r_err = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_ce) r_ce++;
            if (mem_rr) begin r_rr++; if (r_rr_at < 0) r_rr_at = c; end
            if (mem_we) begin r_we++; if (r_we_at < 0) r_we_at = c; r_wd = mem_wdata; end
            if ((mem_we && mem_rr) || (mem_w_mask != (mem_we ? 4'hf : 4'h0)) ||
                (mem_r_mask != (mem_rr ? 4'hf : 4'h0)) ||
                (mem_ce && mem_addr != {a[31:2], 2'b00}) ||
                (!mem_ce && (mem_we || mem_rr || mem_addr != 0)) ||
                (!mem_we && mem_wdata != 0) || (!resp_valid && resp_err))
                r_viol++;
            if (resp_valid) begin
                r_lat = c; r_rd = resp_rdata; r_err = resp_err;
                if (req_ready) r_viol++;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({req_ready, resp_valid, resp_err, mem_ce, mem_we, mem_rr} !== 6'b100000) begin
            n_bad++; $display("FAIL reset_ctl got %b want 100000",
                {req_ready, resp_valid, resp_err, mem_ce, mem_we, mem_rr});
        end
        n_cmp++;
        if ({resp_rdata, mem_addr, mem_wdata, mem_w_mask, mem_r_mask} !== '0) begin
            n_bad++; $display("FAIL reset_data got %h/%h/%h/%h/%h want 0",
                resp_rdata, mem_addr, mem_wdata, mem_w_mask, mem_r_mask);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_loads;
        do_req(1'b1, 2'd2, 1'b0, 32'h0, 32'hfffffadb);
        do_req(1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
        n_cmp++; if (r_lat !== 2 || r_err !== 1'b0) begin n_bad++;
            $display("FAIL lb_lat got lat %0d err %b want 2 0", r_lat, r_err); end
        n_cmp++; if (r_rd !== 32'hffffffdb) begin n_bad++;
            $display("FAIL lb_rdata got %h want ffffffdb", r_rd); end
        do_req(1'b0, 2'd0, 1'b1, 32'h0, 32'h0);
        n_cmp++; if (r_rd !== 32'h000000db) begin n_bad++;
            $display("FAIL lbu_rdata got %h want 000000db", r_rd); end
        do_req(1'b0, 2'd1, 1'b0, 32'h2, 32'h0);
        n_cmp++; if (r_rd !== 32'hffffffff || r_rr !== 1) begin n_bad++;
            $display("FAIL lh_rdata got %h rr %0d want ffffffff 1", r_rd, r_rr); end
        do_req(1'b0, 2'd1, 1'b1, 32'h0, 32'h0);
        n_cmp++; if (r_rd !== 32'h0000fadb || r_rr !== 1 || r_viol !== 0) begin n_bad++;
            $display("FAIL lhu_rdata got %h rr %0d viol %0d want 0000fadb 1 0", r_rd, r_rr, r_viol); end
    endtask

    task automatic test_subword_stores;
        do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h0000288b);
        do_req(1'b1, 2'd0, 1'b0, 32'h7, 32'hffffff12);
        n_cmp++; if (r_rr_at !== 1 || r_we_at !== 2 || r_lat !== 3) begin n_bad++;
            $display("FAIL sb_timing got rr@%0d we@%0d resp@%0d want 1 2 3", r_rr_at, r_we_at, r_lat); end
        n_cmp++; if (r_wd !== 32'h1200288b || r_rd !== 0 || r_viol !== 0) begin n_bad++;
            $display("FAIL sb_wdata got %h rd %h viol %0d want 1200288b 0 0", r_wd, r_rd, r_viol); end
        do_req(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
        n_cmp++; if (r_rd !== 32'h1200288b) begin n_bad++;
            $display("FAIL sb_readback got %h want 1200288b", r_rd); end
        do_req(1'b1, 2'd2, 1'b0, 32'h4, 32'h0000288b);
        do_req(1'b1, 2'd1, 1'b0, 32'h6, 32'h5555beef);
        n_cmp++; if (r_wd !== 32'hbeef288b || r_lat !== 3) begin n_bad++;
            $display("FAIL sh_wdata got %h lat %0d want beef288b 3", r_wd, r_lat); end
    endtask

    task automatic test_word_store;
        do_req(1'b1, 2'd2, 1'b0, 32'h8, 32'hdeadbeef);
        n_cmp++; if (r_we_at !== 1 || r_lat !== 2 || r_rr !== 0) begin n_bad++;
            $display("FAIL sw_timing got we@%0d resp@%0d rr %0d want 1 2 0", r_we_at, r_lat, r_rr); end
        do_req(1'b0, 2'd2, 1'b0, 32'h8, 32'h0);
        n_cmp++; if (r_rd !== 32'hdeadbeef) begin n_bad++;
            $display("FAIL sw_readback got %h want deadbeef", r_rd); end
        do_req(1'b1, 2'd2, 1'b0, 32'hffc, 32'h600dcafe);
        do_req(1'b0, 2'd2, 1'b0, 32'hffc, 32'h0);
        n_cmp++; if (r_rd !== 32'h600dcafe || r_err !== 1'b0) begin n_bad++;
            $display("FAIL last_word got %h err %b want 600dcafe 0", r_rd, r_err); end
    endtask

    task automatic test_errors;
        logic [31:0] ea [5] = '{32'h6, 32'h3, 32'h0, 32'h1000, 32'h1003};
        logic [1:0]  es [5] = '{2'd2, 2'd1, 2'd3, 2'd2, 2'd0};
        logic        ew [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 5; i++) begin
            do_req(ew[i], es[i], 1'b0, ea[i], 32'h12345678);
            n_cmp++;
            if (r_err !== 1'b1 || r_lat !== 1 || r_ce !== 0 || r_rd !== 0) begin n_bad++;
                $display("FAIL err_case%0d got err %b lat %0d ce %0d rd %h want 1 1 0 0",
                    i, r_err, r_lat, r_ce, r_rd); end
        end
    endtask

    task automatic test_back_to_back;
        int nresp, prev, gap_bad;
        nresp = 0; prev = -9; gap_bad = 0;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h8; req_unsigned = 1'b0;
        @(posedge clk);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (c - prev < 3 || req_ready || resp_rdata !== 32'hdeadbeef) gap_bad++;
                prev = c; nresp++;
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (nresp !== 4 || gap_bad !== 0) begin n_bad++;
            $display("FAIL back_to_back got %0d resps %0d bad want 4 0", nresp, gap_bad); end
    endtask

    task automatic test_reset_mid;
        int stray;
        stray = 0;
        do_req(1'b1, 2'd2, 1'b0, 32'hc, 32'h11223344);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_addr = 32'hd; req_wdata = 32'haa;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (mem_we !== 1'b1) begin n_bad++;
            $display("FAIL rst_mid_pre got we %b want 1", mem_we); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if ({mem_ce, mem_we, mem_rr} !== 3'b000) begin n_bad++;
            $display("FAIL rst_mid_drop got ce/we/rr %b want 000", {mem_ce, mem_we, mem_rr}); end
        repeat (2) begin @(negedge clk); if (resp_valid) stray++; end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); if (resp_valid) stray++; end
        n_cmp++; if (req_ready !== 1'b1 || stray !== 0) begin n_bad++;
            $display("FAIL rst_mid_after got ready %b stray %0d want 1 0", req_ready, stray); end
        do_req(1'b0, 2'd2, 1'b0, 32'hc, 32'h0);
        n_cmp++; if (r_rd !== 32'h11223344) begin n_bad++;
            $display("FAIL rst_mid_word got %h want 11223344", r_rd); end
    endtask

    task automatic test_random;
        logic        we, uns, e;
        logic [1:0]  sz;
        logic [31:0] a, wd, exp_rd;
        int          el;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = $urandom;
            do_req(1'b1, 2'd2, 1'b0, 32'(i * 4), ref_mem[i]);
        end
        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom);
            uns = 1'($urandom);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 7) == 0) a = 32'h1000 + ($urandom & 32'h0fff_fffc);
            else a = ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
            wd = $urandom;
            e = exp_err(sz, a);
            exp_rd = 0;
            if (e) el = 1;
            else if (!we || sz == 2'd2) el = 2;
            else el = 3;
            if (!e && !we) exp_rd = exp_load(ref_mem[a[5:2]], sz, uns, a);
            do_req(we, sz, uns, a, wd);
            if (!e && we) ref_mem[a[5:2]] = exp_merge(ref_mem[a[5:2]], sz, a, wd);
            n_cmp++; if (r_err !== e || r_lat !== el || r_viol !== 0) begin n_bad++;
                $display("FAIL rnd%0d_ctl a=%h sz=%0d we=%b got err %b lat %0d viol %0d want %b %0d 0",
                    n, a, sz, we, r_err, r_lat, r_viol, e, el); end
            n_cmp++; if (r_rd !== exp_rd) begin n_bad++;
                $display("FAIL rnd%0d_rdata a=%h sz=%0d uns=%b got %h want %h",
                    n, a, sz, uns, r_rd, exp_rd); end
        end
        for (int i = 0; i < 16; i++) begin
            do_req(1'b0, 2'd2, 1'b0, 32'(i * 4), 32'h0);
            n_cmp++; if (r_rd !== ref_mem[i]) begin n_bad++;
                $display("FAIL rnd_final_w%0d got %h want %h", i, r_rd, ref_mem[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_subword_stores();
        test_word_store();
        test_errors();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
